zero_flag_pipe: RTL and testbench

Parametrised, pipelined zero/negative detector with an architectural NZCV condition-flag register for the 5-stage CPU's execute/memory boundary. It reduces a WIDTH-bit ALU result through a GROUP-input NOR/AND gate tree split across PIPE_STAGES register stages. It carries per-op valid and set-flags bits through the pipeline and commits NZCV at the pipeline tail. It supports stall and flush from the hazard unit, and its outputs feed CBZ/CBNZ resolution and B.cond evaluation.

---
 rtl/zero_flag_pipe.sv | 217 +++++++++++++++++++++
 tb/tb_zero_flag_pipe.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/zero_flag_pipe.sv
// zero_flag_pipe
// Pipelined zero/negative detector with an architectural NZCV flag register.
// It sits at the execute/memory boundary. A WIDTH-bit ALU result is reduced
// through a GROUP-input gate tree. The first level is NOR and every later
// level is AND. PIPE_STAGES register stages are spread across the tree's
// levels, and each stage carries the op's valid, set_flags, N, C and V bits
// beside the partial reduction.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   in_valid   op present at the input this cycle
//   data       ALU result to test
//   carry_in   ALU carry-out for this op
//   ovf_in     ALU overflow for this op
//   set_flags  op writes NZCV
//   stall      freeze pipeline and flag register
//   flush      kill all in-flight ops (wins over stall)
//   out_valid  op valid at pipeline tail
//   zero       tail op's data was all zeros (0 when out_valid=0)
//   negative   tail op's data MSB (0 when out_valid=0)
//   flags      committed {N,Z,C,V}
module zero_flag_pipe #(
  parameter int WIDTH       = 64,
  parameter int GROUP       = 4,
  parameter int PIPE_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] data,
  input  logic             carry_in,
  input  logic             ovf_in,
  input  logic             set_flags,
  input  logic             stall,
  input  logic             flush,
  output logic             out_valid,
  output logic             zero,
  output logic             negative,
  output logic [3:0]       flags
);

  // Number of gate levels needed to reduce WIDTH bits to one.
  function automatic int calc_levels(input int w);
    int n;
    int lv;
    n  = w;
    lv = 0;
    while (n > 1) begin
      n  = (n + GROUP - 1) / GROUP;
      lv = lv + 1;
    end
    return lv;
  endfunction

  localparam int LEVELS = calc_levels(WIDTH);

  // Input count of level lvl. lvl_n(LEVELS+1) is 1, the final result.
  function automatic int lvl_n(input int lvl);
    int n;
    n = WIDTH;
    for (int i = 1; i < lvl; i++) begin
      n = (n + GROUP - 1) / GROUP;
    end
    return n;
  endfunction

  // Level whose output stage s registers. The last stage always closes the tree.
  function automatic int cut_level(input int s);
    return (s * LEVELS + PIPE_STAGES - 1) / PIPE_STAGES;
  endfunction

  // Stage registered at the output of level lvl, or 0 if that output is combinational.
  function automatic int stage_at(input int lvl);
    int r;
    r = 0;
    for (int s = 1; s <= PIPE_STAGES; s++) begin
      if (cut_level(s) == lvl) begin
        r = s;
      end
    end
    return r;
  endfunction

  // Bit offsets into the flat level-output and stage-partial vectors.
  function automatic int lvl_off(input int lvl);
    int o;
    o = 0;
    for (int i = 1; i < lvl; i++) begin
      o = o + lvl_n(i + 1);
    end
    return o;
  endfunction

  function automatic int stg_off(input int s);
    int o;
    o = 0;
    for (int i = 1; i < s; i++) begin
      o = o + lvl_n(cut_level(i) + 1);
    end
    return o;
  endfunction

  localparam int LVL_BITS = lvl_off(LEVELS + 1);
  localparam int STG_BITS = stg_off(PIPE_STAGES + 1);
  localparam int TAIL     = PIPE_STAGES - 1;

  logic [LVL_BITS-1:0]    w_lvl_out;
  logic [STG_BITS-1:0]    w_part_d;
  logic [STG_BITS-1:0]    r_part;
  logic [PIPE_STAGES-1:0] w_vld_d, w_sf_d, w_n_d, w_c_d, w_v_d;
  logic [PIPE_STAGES-1:0] r_vld, r_sf, r_n, r_c, r_v;
  logic [3:0]             r_flags;
  logic                   w_commit;

  // Gate tree. Each level draws its inputs from the raw data (level 1), from
  // the stage register that closed the previous level, or straight from the
  // previous level's combinational output.
  for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
    localparam int   N_IN    = lvl_n(l);
    localparam int   N_OUT   = lvl_n(l + 1);
    localparam int   N_PAD   = N_OUT * GROUP - N_IN;
    localparam int   SRC_STG = stage_at(l - 1);
    // Zero pads are neutral for NOR; one pads are neutral for AND.
    localparam logic PAD_BIT = (l == 1) ? 1'b0 : 1'b1;

    logic [N_IN-1:0]        w_in;
    logic [N_OUT*GROUP-1:0] w_pad;
    logic [N_OUT-1:0]       w_red;

    if (l == 1) begin : g_src_data
      assign w_in = data;
    end else if (SRC_STG > 0) begin : g_src_reg
      assign w_in = r_part[stg_off(SRC_STG) +: N_IN];
    end else begin : g_src_comb
      assign w_in = w_lvl_out[lvl_off(l - 1) +: N_IN];
    end

    if (N_PAD > 0) begin : g_pad
      assign w_pad = {{N_PAD{PAD_BIT}}, w_in};
    end else begin : g_nopad
      assign w_pad = w_in;
    end

    for (genvar g = 0; g < N_OUT; g++) begin : g_gate
      if (l == 1) begin : g_nor
        assign w_red[g] = ~|w_pad[g*GROUP +: GROUP];
      end else begin : g_and
        assign w_red[g] = &w_pad[g*GROUP +: GROUP];
      end
    end

    assign w_lvl_out[lvl_off(l) +: N_OUT] = w_red;
  end

  // Next-state for each stage: stage 1 takes the input op, later stages
  // shift the sideband bits along with the partial results.
  for (genvar s = 1; s <= PIPE_STAGES; s++) begin : g_stg
    localparam int SW = lvl_n(cut_level(s) + 1);

    assign w_part_d[stg_off(s) +: SW] = w_lvl_out[lvl_off(cut_level(s)) +: SW];

    if (s == 1) begin : g_head
      assign w_vld_d[0] = in_valid;
      assign w_sf_d[0]  = set_flags;
      assign w_n_d[0]   = data[WIDTH-1];
      assign w_c_d[0]   = carry_in;
      assign w_v_d[0]   = ovf_in;
    end else begin : g_body
      assign w_vld_d[s-1] = r_vld[s-2];
      assign w_sf_d[s-1]  = r_sf[s-2];
      assign w_n_d[s-1]   = r_n[s-2];
      assign w_c_d[s-1]   = r_c[s-2];
      assign w_v_d[s-1]   = r_v[s-2];
    end
  end

  // Pipeline registers: flush drops valid bits only, stall holds everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld  <= {PIPE_STAGES{1'b0}};
      r_sf   <= {PIPE_STAGES{1'b0}};
      r_n    <= {PIPE_STAGES{1'b0}};
      r_c    <= {PIPE_STAGES{1'b0}};
      r_v    <= {PIPE_STAGES{1'b0}};
      r_part <= {STG_BITS{1'b0}};
    end else if (flush) begin
      r_vld <= {PIPE_STAGES{1'b0}};
    end else if (!stall) begin
      r_vld  <= w_vld_d;
      r_sf   <= w_sf_d;
      r_n    <= w_n_d;
      r_c    <= w_c_d;
      r_v    <= w_v_d;
      r_part <= w_part_d;
    end
  end

  // Tail outputs are gated by valid so bubbles never show stale payload.
  assign out_valid = r_vld[TAIL];
  assign zero      = r_vld[TAIL] & r_part[STG_BITS-1];
  assign negative  = r_vld[TAIL] & r_n[TAIL];

  assign w_commit = r_vld[TAIL] & r_sf[TAIL] & ~stall & ~flush;

  // Architectural NZCV register. It commits the tail op when the pipeline advances.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flags <= 4'b0000;
    end else if (w_commit) begin
      r_flags <= {negative, zero, r_c[TAIL], r_v[TAIL]};
    end
  end

  assign flags = r_flags;

endmodule

// File: tb/tb_zero_flag_pipe.sv
// Directed bench for zero_flag_pipe. It has a 64/4/2 instance and two
// 37-bit GROUP=3 instances with PIPE_STAGES=1 and PIPE_STAGES=3. All three
// share the control inputs.
module tb_zero_flag_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, carry_in, ovf_in, set_flags, stall, flush;
  logic [63:0] data64;
  logic [36:0] data37;

  logic       ov_m, z_m, n_m;
  logic [3:0] f_m;
  logic       ov_a, z_a, n_a;
  logic [3:0] f_a;
  logic       ov_b, z_b, n_b;
  logic [3:0] f_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  zero_flag_pipe #(.WIDTH(64), .GROUP(4), .PIPE_STAGES(2)) u_dut_main (
    .clk(clk), .reset(reset), .in_valid(in_valid), .data(data64),
    .carry_in(carry_in), .ovf_in(ovf_in), .set_flags(set_flags),
    .stall(stall), .flush(flush), .out_valid(ov_m), .zero(z_m),
    .negative(n_m), .flags(f_m)
  );

  zero_flag_pipe #(.WIDTH(37), .GROUP(3), .PIPE_STAGES(1)) u_dut_p1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .data(data37),
    .carry_in(carry_in), .ovf_in(ovf_in), .set_flags(set_flags),
    .stall(stall), .flush(flush), .out_valid(ov_a), .zero(z_a),
    .negative(n_a), .flags(f_a)
  );

  zero_flag_pipe #(.WIDTH(37), .GROUP(3), .PIPE_STAGES(3)) u_dut_p3 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .data(data37),
    .carry_in(carry_in), .ovf_in(ovf_in), .set_flags(set_flags),
    .stall(stall), .flush(flush), .out_valid(ov_b), .zero(z_b),
    .negative(n_b), .flags(f_b)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] d, input logic sf);
    in_valid  = v;
    data64    = d;
    data37    = d[36:0];
    set_flags = sf;
  endtask

  logic [63:0] vec_d [4];
  logic        vec_z [4];
  logic        vec_n [4];
  logic [3:0]  vec_f [4];
  logic [63:0] one64;

  initial begin
    one64 = 64'd1;
    vec_d[0] = 64'h0000000000000000; vec_z[0] = 1'b1; vec_n[0] = 1'b0; vec_f[0] = 4'b0110;
    vec_d[1] = 64'h8000000000000000; vec_z[1] = 1'b0; vec_n[1] = 1'b1; vec_f[1] = 4'b1010;
    vec_d[2] = 64'h0000000000000001; vec_z[2] = 1'b0; vec_n[2] = 1'b0; vec_f[2] = 4'b0010;
    vec_d[3] = 64'hFFFFFFFFFFFFFFFF; vec_z[3] = 1'b0; vec_n[3] = 1'b1; vec_f[3] = 4'b1010;

    // Outputs are held at zero while reset is high, even with an op at the input.
    reset = 1'b1; stall = 1'b0; flush = 1'b0; carry_in = 1'b0; ovf_in = 1'b0;
    drive(1'b1, 64'h0, 1'b0);
    step(); step();
    check_eq("rst_valid", {63'd0, ov_m}, 64'd0);
    check_eq("rst_zero",  {63'd0, z_m},  64'd0);
    check_eq("rst_neg",   {63'd0, n_m},  64'd0);
    check_eq("rst_flags", {60'd0, f_m},  64'd0);

    // The first op after reset appears two edges after it is accepted.
    reset = 1'b0;
    step();
    drive(1'b0, 64'h0, 1'b0);
    check_eq("lat_early_valid", {63'd0, ov_m}, 64'd0);
    step();
    check_eq("lat_valid", {63'd0, ov_m}, 64'd1);
    check_eq("lat_zero",  {63'd0, z_m},  64'd1);
    check_eq("lat_neg",   {63'd0, n_m},  64'd0);
    step();
    check_eq("noset_flags", {60'd0, f_m}, 64'd0);

    // Back-to-back flag-setting stream.
    carry_in = 1'b1; ovf_in = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c < 4) drive(1'b1, vec_d[c], 1'b1);
      else       drive(1'b0, 64'h0, 1'b0);
      step();
      if (c >= 1 && c <= 4) begin
        check_eq($sformatf("strm_valid[%0d]", c - 1), {63'd0, ov_m}, 64'd1);
        check_eq($sformatf("strm_zero[%0d]", c - 1),  {63'd0, z_m},  {63'd0, vec_z[c-1]});
        check_eq($sformatf("strm_neg[%0d]", c - 1),   {63'd0, n_m},  {63'd0, vec_n[c-1]});
      end
      if (c >= 2) begin
        check_eq($sformatf("strm_flags[%0d]", c - 2), {60'd0, f_m}, {60'd0, vec_f[c-2]});
      end
    end
    check_eq("strm_bubble_valid", {63'd0, ov_m}, 64'd0);
    check_eq("strm_bubble_zero",  {63'd0, z_m},  64'd0);

    // Single-bit sweep followed by all-zero data.
    carry_in = 1'b0; ovf_in = 1'b1;
    for (int c = 0; c < 66; c++) begin
      if (c < 64)       drive(1'b1, one64 << c, 1'b1);
      else if (c == 64) drive(1'b1, 64'h0, 1'b1);
      else              drive(1'b0, 64'h0, 1'b0);
      step();
      if (c >= 1) begin
        check_eq($sformatf("sweep_zero[%0d]", c - 1), {63'd0, z_m}, {63'd0, (c - 1) == 64});
        check_eq($sformatf("sweep_neg[%0d]", c - 1),  {63'd0, n_m}, {63'd0, (c - 1) == 63});
      end
    end
    drive(1'b0, 64'h0, 1'b0);
    step();
    check_eq("sweep_flags", {60'd0, f_m}, {60'd0, 4'b0101});

    // A stall holds the tail op and the flags until it drops.
    carry_in = 1'b0; ovf_in = 1'b0;
    drive(1'b1, 64'h0, 1'b1);
    step();
    drive(1'b0, 64'h0, 1'b0);
    step();
    check_eq("stall_pre_valid", {63'd0, ov_m}, 64'd1);
    stall = 1'b1;
    drive(1'b1, 64'h5, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq($sformatf("stall_valid[%0d]", i), {63'd0, ov_m}, 64'd1);
      check_eq($sformatf("stall_zero[%0d]", i),  {63'd0, z_m},  64'd1);
      check_eq($sformatf("stall_flags[%0d]", i), {60'd0, f_m},  {60'd0, 4'b0101});
    end
    stall = 1'b0;
    drive(1'b0, 64'h0, 1'b0);
    step();
    check_eq("stall_commit_flags", {60'd0, f_m},  {60'd0, 4'b0100});
    check_eq("stall_after_valid",  {63'd0, ov_m}, 64'd0);
    step();
    check_eq("stall_ignored_valid", {63'd0, ov_m}, 64'd0);

    // Flush: first set the flags to 1000, then kill an op in flight.
    drive(1'b1, 64'h8000000000000000, 1'b1);
    step();
    drive(1'b0, 64'h0, 1'b0);
    step(); step();
    check_eq("flush_prior_flags", {60'd0, f_m}, {60'd0, 4'b1000});
    drive(1'b1, 64'h0, 1'b1);
    step();
    drive(1'b0, 64'h0, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_eq("flush_valid",  {63'd0, ov_m}, 64'd0);
    check_eq("flush_flags",  {60'd0, f_m},  {60'd0, 4'b1000});
    step();
    check_eq("flush_gone",   {63'd0, ov_m}, 64'd0);
    check_eq("flush_flags2", {60'd0, f_m},  {60'd0, 4'b1000});

    // Flush together with stall, with the op at the tail and a new op at the input.
    drive(1'b1, 64'h0, 1'b1);
    step();
    drive(1'b0, 64'h0, 1'b0);
    step();
    check_eq("flst_pre_valid", {63'd0, ov_m}, 64'd1);
    flush = 1'b1; stall = 1'b1;
    drive(1'b1, 64'h0, 1'b1);
    step();
    check_eq("flst_valid", {63'd0, ov_m}, 64'd0);
    check_eq("flst_flags", {60'd0, f_m},  {60'd0, 4'b1000});
    flush = 1'b0; stall = 1'b0;
    drive(1'b0, 64'h0, 1'b0);
    step();
    check_eq("flst_drop_valid", {63'd0, ov_m}, 64'd0);
    step();
    check_eq("flst_drop_valid2", {63'd0, ov_m}, 64'd0);
    check_eq("flst_flags2",      {60'd0, f_m},  {60'd0, 4'b1000});

    // 37-bit, GROUP=3 instances: latency is PIPE_STAGES edges.
    reset = 1'b1;
    step();
    reset = 1'b0;
    carry_in = 1'b1; ovf_in = 1'b0;
    drive(1'b1, 64'h0, 1'b1);
    step();
    check_eq("p1_op0_valid", {63'd0, ov_a}, 64'd1);
    check_eq("p1_op0_zero",  {63'd0, z_a},  64'd1);
    check_eq("p1_op0_neg",   {63'd0, n_a},  64'd0);
    check_eq("p3_e1_valid",  {63'd0, ov_b}, 64'd0);
    drive(1'b1, 64'h0000001000000000, 1'b1);
    step();
    check_eq("p1_op1_zero",  {63'd0, z_a},  64'd0);
    check_eq("p1_op1_neg",   {63'd0, n_a},  64'd1);
    check_eq("p1_flags0",    {60'd0, f_a},  {60'd0, 4'b0110});
    check_eq("p3_e2_valid",  {63'd0, ov_b}, 64'd0);
    drive(1'b0, 64'h0, 1'b0);
    step();
    check_eq("p3_op0_valid", {63'd0, ov_b}, 64'd1);
    check_eq("p3_op0_zero",  {63'd0, z_b},  64'd1);
    check_eq("p3_op0_neg",   {63'd0, n_b},  64'd0);
    check_eq("p1_flags1",    {60'd0, f_a},  {60'd0, 4'b1010});
    check_eq("p1_idle",      {63'd0, ov_a}, 64'd0);
    step();
    check_eq("p3_op1_zero",  {63'd0, z_b},  64'd0);
    check_eq("p3_op1_neg",   {63'd0, n_b},  64'd1);
    check_eq("p3_flags0",    {60'd0, f_b},  {60'd0, 4'b0110});
    step();
    check_eq("p3_flags1",    {60'd0, f_b},  {60'd0, 4'b1010});

    // Asynchronous reset mid-stream clears flags and in-flight ops at once.
    drive(1'b1, 64'h0, 1'b1);
    step();
    #2;
    reset = 1'b1;
    #1;
    check_eq("arst_p1_flags",   {60'd0, f_a},  64'd0);
    check_eq("arst_p3_flags",   {60'd0, f_b},  64'd0);
    check_eq("arst_p1_valid",   {63'd0, ov_a}, 64'd0);
    check_eq("arst_main_flags", {60'd0, f_m},  64'd0);
    drive(1'b0, 64'h0, 1'b0);
    #1;
    reset = 1'b0;
    step();
    check_eq("arst_post_p1_flags", {60'd0, f_a},  64'd0);
    check_eq("arst_post_p3_flags", {60'd0, f_b},  64'd0);
    check_eq("arst_post_p3_valid", {63'd0, ov_b}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
